// File: rtl/sseg_scan_ctrl_if.sv
// User-side load bus and display pin bundle for sseg_scan_ctrl.
// master = user logic / board side, slave = the scan controller.
interface sseg_scan_ctrl_if;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic [7:0]  blank_in;
  logic        load;
  logic        load_ack;
  logic        frame_tick;
  logic [7:0]  an;
  logic [6:0]  sseg;
  logic        dp;

  modport master (
    output data_in, dp_in, blank_in, load,
    input  load_ack, frame_tick, an, sseg, dp
  );

  modport slave (
    input  data_in, dp_in, blank_in, load,
    output load_ack, frame_tick, an, sseg, dp
  );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// 8-digit common-anode seven-segment scan controller with double-buffered display data.
// Optional leading-zero blanking is enabled by defining SSEG_LZB_EN.
module sseg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  sseg_scan_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic             pend_vld;
  logic [31:0]      pend_data;
  logic [7:0]       pend_dp;
  logic [7:0]       pend_blank;
  logic [31:0]      act_data;
  logic [7:0]       act_dp;
  logic [7:0]       act_blank;
  logic [7:0]       an_q;
  logic [6:0]       sseg_q;
  logic             dp_q;
  logic             load_ack_q;
  logic             frame_tick_q;

  logic             slot_end;
  logic             frame_end;
  logic [CNT_W-1:0] cnt_nxt;
  logic [3:0]       nib;
  logic [6:0]       seg;
  logic [7:0]       lzb;
  logic [7:0]       dark;

  assign slot_end  = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (idx == 3'd7);
  assign cnt_nxt   = slot_end ? '0 : cnt + CNT_W'(1);
  assign nib       = act_data[{idx, 2'b00} +: 4];
  assign dark      = act_blank | lzb;

  // Hex nibble to active-low {g,f,e,d,c,b,a}
  always_comb begin
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

`ifdef SSEG_LZB_EN
  // Digit i (i>0) is dark when it and every higher nibble are zero; digit 0 always shows
  always_comb begin
    lzb = '0;
    for (int i = 1; i < 8; i++) begin
      lzb[i] = ~|(act_data >> (4 * i));
    end
  end
`else
  assign lzb = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;
      cnt          <= '0;
      idx          <= '0;
      pend_vld     <= 1'b0;
      pend_data    <= '0;
      pend_dp      <= '0;
      pend_blank   <= '0;
      act_data     <= '0;
      act_dp       <= '0;
      act_blank    <= '0;
      an_q         <= 8'hFF;
      sseg_q       <= 7'h7F;
      dp_q         <= 1'b1;
      load_ack_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      frame_tick_q <= frame_end;
      load_ack_q   <= 1'b0;
      if (slot_end) begin
        idx <= idx + 3'd1;
      end
      state <= (cnt_nxt < CNT_W'(BLANK_CYC)) ? ST_BLANK : ST_SHOW;

      // Output register: one cycle behind the counter/index state
      case (state)
        ST_SHOW: begin
          an_q   <= dark[idx] ? 8'hFF : ~(8'b1 << idx);
          sseg_q <= seg;
          dp_q   <= ~act_dp[idx];
        end
        default: begin
          an_q   <= 8'hFF;
          sseg_q <= 7'h7F;
          dp_q   <= 1'b1;
        end
      endcase

      // A load on the boundary itself bypasses the pending buffer
      if (frame_end && bus.load) begin
        act_data   <= bus.data_in;
        act_dp     <= bus.dp_in;
        act_blank  <= bus.blank_in;
        pend_vld   <= 1'b0;
        load_ack_q <= 1'b1;
      end else if (frame_end && pend_vld) begin
        act_data   <= pend_data;
        act_dp     <= pend_dp;
        act_blank  <= pend_blank;
        pend_vld   <= 1'b0;
        load_ack_q <= 1'b1;
      end else if (bus.load) begin
        pend_data  <= bus.data_in;
        pend_dp    <= bus.dp_in;
        pend_blank <= bus.blank_in;
        pend_vld   <= 1'b1;
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.sseg       = sseg_q;
  assign bus.dp         = dp_q;
  assign bus.load_ack   = load_ack_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl (REFRESH_DIV=8, BLANK_CYC=2); expected frames are queued
// when data is loaded and popped cycle by cycle while the display scans.
module tb_sseg_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sseg_scan_ctrl_if bus ();

  sseg_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYC(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks  = 0;
  int errors  = 0;
  int ack_cnt = 0;
  logic [15:0] sb[$];
  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.load_ack === 1'b1) ack_cnt++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lzb_mask(input logic [31:0] d);
    logic [7:0] m;
    int top;
    m = '0;
`ifdef SSEG_LZB_EN
    top = 0;
    for (int i = 0; i < 8; i++) if (d[i*4 +: 4] != 4'h0) top = i;
    for (int i = 0; i < 8; i++) if (i > top) m[i] = 1'b1;
`else
    top = 0;
`endif
    return m;
  endfunction

  // Expected {an, sseg, dp} for each of the 64 cycles of one frame
  task automatic push_frame(input logic [31:0] d, input logic [7:0] dpm, input logic [7:0] blk);
    logic [7:0] drk;
    logic [7:0] an_e;
    drk = blk | lzb_mask(d);
    for (int dig = 0; dig < 8; dig++) begin
      for (int c = 0; c < 8; c++) begin
        if (c < 2) begin
          sb.push_back({8'hFF, 7'h7F, 1'b1});
        end else begin
          an_e = drk[dig] ? 8'hFF : ~(8'h01 << dig);
          sb.push_back({an_e, seg_tbl[d[dig*4 +: 4]], ~dpm[dig]});
        end
      end
    end
  endtask

  task automatic check_frame(input string tag);
    logic [15:0] exp;
    for (int k = 0; k < 64; k++) begin
      step();
      if (sb.size() == 0) begin
        chk($sformatf("%s_sb_empty_%0d", tag, k), 32'd0, 32'd1);
      end else begin
        exp = sb.pop_front();
        chk($sformatf("%s_cyc%0d", tag, k), {16'h0, bus.an, bus.sseg, bus.dp}, {16'h0, exp});
      end
    end
    chk({tag, "_end_tick"}, bus.frame_tick, 1);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.frame_tick !== 1'b1 && n < 200);
    chk("frame_tick_seen", bus.frame_tick, 1);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] dpm, input logic [7:0] blk);
    bus.data_in  = d;
    bus.dp_in    = dpm;
    bus.blank_in = blk;
    bus.load     = 1'b1;
    step();
    bus.load     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ack0;
    bus.data_in  = '0;
    bus.dp_in    = '0;
    bus.blank_in = '0;
    bus.load     = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    step();
    chk("rst_an", bus.an, 8'hFF);
    chk("rst_sseg", bus.sseg, 7'h7F);
    chk("rst_dp", bus.dp, 1);
    chk("rst_ack", bus.load_ack, 0);
    chk("rst_tick", bus.frame_tick, 0);
    rst_n = 1'b1;
    step(); chk("rel_c1_an", bus.an, 8'hFF);
    step(); chk("rel_c2_an", bus.an, 8'hFF);
    step(); chk("rel_c3", {bus.an, bus.sseg, bus.dp}, {8'hFE, 7'h40, 1'b1});
    step(); step();

    // Mid-slot reset goes dark without waiting for a clock
    rst_n = 1'b0;
    #1;
    chk("midrst_dark", {bus.an, bus.sseg, bus.dp}, {8'hFF, 7'h7F, 1'b1});
    step();
    rst_n = 1'b1;
    step(); chk("restart_c1_an", bus.an, 8'hFF);
    step(); chk("restart_c2_an", bus.an, 8'hFF);
    step(); chk("restart_c3", {bus.an, bus.sseg, bus.dp}, {8'hFE, 7'h40, 1'b1});
    wait_tick(n);
    chk("first_tick_latency", n, 61);
    chk("no_ack_without_load", ack_cnt, 0);

    // Single load mid-frame is acked at the next boundary
    do_load(32'h12345678, 8'h00, 8'h00);
    ack0 = ack_cnt;
    wait_tick(n);
    chk("ack_with_tick", bus.load_ack, 1);
    chk("ack_count_1", ack_cnt - ack0, 1);
    push_frame(32'h12345678, 8'h00, 8'h00);
    check_frame("f12345678");
    chk("no_extra_ack", bus.load_ack, 0);

    // Two loads in one frame: last write wins, one ack
    ack0 = ack_cnt;
    do_load(32'h00000000, 8'h00, 8'h00);
    step(); step();
    do_load(32'hFFFFFFFF, 8'h00, 8'h00);
    wait_tick(n);
    chk("double_load_ack", ack_cnt - ack0, 1);
    push_frame(32'hFFFFFFFF, 8'h00, 8'h00);
    check_frame("fFFFFFFFF");

    // Decimal point on digit 0, digit 7 blanked
    do_load(32'h89ABCDEF, 8'h01, 8'h80);
    wait_tick(n);
    push_frame(32'h89ABCDEF, 8'h01, 8'h80);
    check_frame("fdp_blank");

    // frame_tick period over three frames
    for (int f = 0; f < 3; f++) begin
      wait_tick(n);
      chk($sformatf("tick_period_%0d", f), n, 64);
    end

    // Load on the boundary cycle bypasses into the very next frame
    for (int k = 0; k < 63; k++) step();
    ack0 = ack_cnt;
    do_load(32'h0F1E2D3C, 8'h00, 8'h00);
    chk("bypass_tick", bus.frame_tick, 1);
    chk("bypass_ack", bus.load_ack, 1);
    push_frame(32'h0F1E2D3C, 8'h00, 8'h00);
    check_frame("fbypass");
    chk("bypass_single_ack", ack_cnt - ack0, 1);

    // Leading-zero cases (blanking applies only when SSEG_LZB_EN is defined)
    do_load(32'h000000A5, 8'h00, 8'h00);
    wait_tick(n);
    push_frame(32'h000000A5, 8'h00, 8'h00);
    check_frame("fA5");
    do_load(32'h00000000, 8'h00, 8'h00);
    wait_tick(n);
    push_frame(32'h00000000, 8'h00, 8'h00);
    check_frame("fzero");

    // No further loads: display holds
    ack0 = ack_cnt;
    push_frame(32'h00000000, 8'h00, 8'h00);
    check_frame("fhold");
    chk("hold_no_ack", ack_cnt - ack0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
